// File: rtl/shared_adder_scheduler.sv
// Shares one 4-bit adder slice between two round-robin requesters.
// Each operation processes one nibble per cycle, least significant nibble first.
module shared_adder_scheduler #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic          prio_r;
  logic          grant_s;
  logic [4:0]    nib_s;

  // One 4-bit slice with carry in; bit 4 of the result is the carry out.
  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    nib_add = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  // Grant selection: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = prio_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Current slice of the shared adder; the bit offset is counter * 4.
  always_comb begin
    nib_s = nib_add(a_r[{cnt_r, 2'b00} +: 4], b_r[{cnt_r, 2'b00} +: 4], carry_r);
  end

  assign req0_ready = !rst && (state_r == IDLE) && req0_valid && (grant_s == 1'b0);
  assign req1_ready = !rst && (state_r == IDLE) && req1_valid && (grant_s == 1'b1);
  assign busy       = (state_r != IDLE);

  // Sequencer: accept, walk the nibbles, then hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      prio_r    <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            a_r     <= grant_s ? req1_a : req0_a;
            b_r     <= grant_s ? req1_b : req0_b;
            res_id  <= grant_s;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            state_r <= ADD;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD: begin
          res_sum[{cnt_r, 2'b00} +: 4] <= nib_s[3:0];
          carry_r                      <= nib_s[4];
          if (cnt_r == LAST_NIB) begin
            res_cout  <= nib_s[4];
            res_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            prio_r    <= ~res_id;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shared_adder_scheduler.md
Name: shared_adder_scheduler

Overview:
- Shares one 4-bit ripple-carry adder stage between two requesters.
- Each request adds two operands of 4*NIBBLES bits, processed one nibble per cycle, least significant nibble first, with the carry chained between nibbles.
- Round-robin arbitration between the two requesters; valid/ready handshake on both the request side and the result side.
- Sits between the client blocks and the nibble adder datapath; it sequences that datapath and delivers the full-width sum and carry-out.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal values are 1 or more.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  scheduler accepts requester 0 this cycle
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  scheduler accepts requester 1 this cycle
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
res_valid  output  1  result available
res_ready  input  1  consumer takes the result
res_sum  output  W  sum, modulo 2^W
res_cout  output  1  carry out of the most significant nibble
res_id  output  1  requester index the result belongs to
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - state IDLE; res_valid 0, res_sum 0, res_cout 0, res_id 0, busy 0.
  - Priority pointer = 0, so requester 0 wins the first tie.
  - req0_ready and req1_ready are forced to 0 while rst is high.
- Reset mid-operation abandons the in-flight operation. No result is produced and no ready pulse follows.
- FSM states: IDLE, ADD, DONE.
- IDLE, grant:
  - grant = the only valid requester; if both are valid, grant = priority pointer.
  - reqX_ready = (state==IDLE) & reqX_valid & (grant==X); this is combinational.
  - At most one ready is high in any cycle.
- IDLE, on accept (reqX_valid & reqX_ready at the edge):
  - Latch operands A and B and the id.
  - Clear the nibble counter to 0 and the carry to 0.
  - Go to ADD.
- IDLE, no valid requester: stay in IDLE.
- A requester may drop valid before it is granted. Nothing is committed in that case.
- ADD, each cycle:
  - {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry, where k = counter.
  - Store s into sum bits [4k+3:4k]; carry <= c; counter++.
  - When k == NIBBLES-1: res_cout <= c and go to DONE.
  - The counter never wraps within an operation.
- DONE:
  - res_valid = 1. res_sum, res_cout and res_id are held stable until res_valid & res_ready.
  - On that handshake: go to IDLE, res_valid <= 0, and the priority pointer moves to the requester not just served.
  - Both reqX_ready stay 0 while in ADD and DONE.
- Latency: the accept edge is cycle 0. Nibbles are computed on cycles 1..NIBBLES. res_valid is first high in the cycle following the edge that computes the last nibble, which is NIBBLES edges after accept.
- Throughput: with res_ready held high, one operation every NIBBLES+2 cycles (accept, NIBBLES adds, result).
- res_sum is only meaningful while res_valid is high. Partial sum bits may be visible during ADD.
- Arithmetic is unsigned, with no overflow flag beyond res_cout.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... A requester waits at most one full operation.

Test Plan:
1. NIBBLES=4: req0 0x1234 + 0x0FFF, res_ready=1 -> res_valid 4 edges after accept; res_sum 0x2233, res_cout 0, res_id 0; busy low the next cycle.
2. req1 0xFFFF + 0x0001 -> res_sum 0x0000, res_cout 1, res_id 1. Then 0x00FF + 0x0001 -> res_sum 0x0100, res_cout 0, confirming carry chaining across nibbles.
3. Both requesters valid continuously from reset, each with distinct operands -> accept order 0,1,0,1. Each result carries the correct id and sum. Never both readys high in one cycle.
4. Backpressure: hold res_ready=0 for 5 cycles after res_valid rises -> res_valid, res_sum, res_cout and res_id stable throughout; req0_ready and req1_ready stay 0; completion on the first res_ready=1 edge.
5. Assert rst for 1 cycle during the 2nd ADD cycle -> the following cycle has busy 0, res_valid 0 and no result for the aborted request. A new req1 accept with both valid is impossible because the pointer is 0: req0 wins a tie. A fresh 0x0001 + 0x0001 completes with res_sum 0x0002.
6. req0_valid pulsed for 1 cycle while the scheduler is in ADD for req1, then dropped -> req0 is never accepted and no spurious result appears.
